// File: rtl/qspi_flash_read_ctrl.sv
// Single-word QSPI NOR read sequencer: command, 24-bit address, dummy, data, then a response handshake.
// Define QSPI_QUAD_EN for quad output read (0x6B, 4 bits per SCLK); otherwise fast read (0x0B, 1 bit per SCLK).
module qspi_flash_read_ctrl #(
  parameter int PRESCALER     = 4,
  parameter int DUMMY_CYCLES  = 6,
  parameter int CS_GAP_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        qspi_cs,
  output logic        qspi_sclk,
  output logic [3:0]  dq_o,
  output logic [3:0]  dq_oe,
  input  logic [3:0]  dq_i,
  output logic        busy,
  output logic [2:0]  dbg_state_o
);

`ifdef QSPI_QUAD_EN
  localparam logic [7:0] CMD_BYTE = 8'h6B;
  localparam int         ND       = 8;
`else
  localparam logic [7:0] CMD_BYTE = 8'h0B;
  localparam int         ND       = 32;
`endif

  localparam logic [3:0] DIV_LAST   = 4'(PRESCALER - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
  localparam logic [7:0] DATA_LAST  = 8'(ND - 1);
  localparam logic [7:0] GAP_LAST   = 8'((CS_GAP_CYCLES > 0) ? CS_GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_RESP, S_GAP
  } state_t;

  state_t      state_q;
  logic [3:0]  div_q;
  logic [7:0]  per_q;
  logic [7:0]  gap_q;
  logic [31:0] tx_q;
  logic [31:0] rx_q;
  logic [31:0] rx_d;
  logic [7:0]  per_last;
  logic        sclk_q;
  logic        cs_q;
  logic        resp_valid_q;
  logic [31:0] resp_data_q;
  logic [3:0]  dq_o_q;
  logic [3:0]  dq_oe_q;

  // Both ports are valid/ready: a transfer happens on the clock edge where valid && ready are both
  // high; the side raising valid keeps its payload stable until then. req_ready is high only in IDLE.
  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign qspi_cs     = cs_q;
  assign qspi_sclk   = sclk_q;
  assign dq_o        = dq_o_q;
  assign dq_oe       = dq_oe_q;

  always_comb begin
    per_last = 8'd0;
    case (state_q)
      S_CMD:   per_last = 8'd7;
      S_ADDR:  per_last = 8'd23;
      S_DUMMY: per_last = DUMMY_LAST;
      S_DATA:  per_last = DATA_LAST;
      default: per_last = 8'd0;
    endcase
  end

`ifdef QSPI_QUAD_EN
  assign rx_d = {rx_q[27:0], dq_i};
`else
  logic unused_dq;
  assign unused_dq = ^{dq_i[3:2], dq_i[0]};
  assign rx_d = {rx_q[30:0], dq_i[1]};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      per_q        <= '0;
      gap_q        <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      sclk_q       <= 1'b0;
      cs_q         <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      dq_o_q       <= '0;
      dq_oe_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            tx_q    <= {CMD_BYTE, req_addr[23:2], 2'b00};
            dq_o_q  <= {3'b000, CMD_BYTE[7]};
            dq_oe_q <= 4'b0001;
            cs_q    <= 1'b0;
            sclk_q  <= 1'b0;
            div_q   <= '0;
            per_q   <= '0;
            rx_q    <= '0;
            state_q <= S_CMD;
          end
        end
        S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + 4'd1;
          end else begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              if (state_q == S_DATA) rx_q <= rx_d;
            end else begin
              // Falling edge: start of the next SCLK period, the only place dq_o may change.
              per_q <= (per_q == per_last) ? 8'd0 : per_q + 8'd1;
              if (state_q == S_CMD || (state_q == S_ADDR && per_q != per_last)) begin
                tx_q   <= {tx_q[30:0], 1'b0};
                dq_o_q <= {3'b000, tx_q[30]};
              end
              if (per_q == per_last) begin
                case (state_q)
                  S_CMD:   state_q <= S_ADDR;
                  S_ADDR: begin
                    state_q <= S_DUMMY;
                    dq_oe_q <= 4'b0000;
                    dq_o_q  <= 4'b0000;
                  end
                  S_DUMMY: state_q <= S_DATA;
                  default: begin
                    state_q      <= S_RESP;
                    cs_q         <= 1'b1;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                  end
                endcase
              end
            end
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            gap_q        <= '0;
            state_q      <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) state_q <= S_IDLE;
          else gap_q <= gap_q + 8'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_flash_read_ctrl.sv
// Bench for qspi_flash_read_ctrl: bus-level flash model, response scoreboard, timing monitors.
module tb_qspi_flash_read_ctrl;

  localparam int P = 4;
  localparam int D = 6;
  localparam int G = 4;
`ifdef QSPI_QUAD_EN
  localparam int         ND      = 8;
  localparam logic [7:0] EXP_CMD = 8'h6B;
`else
  localparam int         ND      = 32;
  localparam logic [7:0] EXP_CMD = 8'h0B;
`endif
  localparam int N       = 32 + D + ND;
  localparam int EXP_LAT = 2 * N * P + 1;

  logic        clock = 0;
  logic        reset = 1;
  logic        req_valid = 0;
  logic        req_ready;
  logic [23:0] req_addr = 0;
  logic        resp_valid;
  logic        resp_ready = 0;
  logic [31:0] resp_data;
  logic        qspi_cs, qspi_sclk, busy;
  logic [3:0]  dq_o, dq_oe;
  logic [3:0]  dq_i = 0;
  logic [2:0]  dbg_state;

  qspi_flash_read_ctrl #(.PRESCALER(P), .DUMMY_CYCLES(D), .CS_GAP_CYCLES(G)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .qspi_cs(qspi_cs), .qspi_sclk(qspi_sclk), .dq_o(dq_o),
    .dq_oe(dq_oe), .dq_i(dq_i), .busy(busy), .dbg_state_o(dbg_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rr_mode = 0;
  int t_req, h_cyc, cs_hi;
  bit lat_armed = 0, gap_armed = 0;
  logic [31:0] exp_q[$];
  logic [23:0] exp_addr_q[$];
  logic [31:0] last_data = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flash content: fixed image at 0..3, hashed pattern elsewhere.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'd0: return 8'h11;
      24'd1: return 8'h22;
      24'd2: return 8'h33;
      24'd3: return 8'h44;
      default: return (a[7:0] * 8'd7) ^ a[15:8] ^ {a[23:20], a[3:0]} ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input logic [23:0] a);
    logic [23:0] b;
    b = {a[23:2], 2'b00};
    return {flash_byte(b + 24'd3), flash_byte(b + 24'd2), flash_byte(b + 24'd1), flash_byte(b)};
  endfunction

  // ---------------- flash device model on the pads ----------------
  int          rise_cnt = 0;
  int          fk;
  logic [7:0]  cmd_sn, fbyte;
  logic [23:0] addr_sn;

  always @(negedge qspi_cs) begin
    rise_cnt = 0; cmd_sn = 0; addr_sn = 0;
  end

  always @(posedge qspi_cs) begin
    if (!reset) chk("sclk_periods", 32'(rise_cnt), 32'(N));
  end

  always @(posedge qspi_sclk) begin
    if (!qspi_cs) begin
      chk("dq_oe", {28'd0, dq_oe}, (rise_cnt < 32) ? 32'h1 : 32'h0);
      if (rise_cnt < 8) cmd_sn = {cmd_sn[6:0], dq_o[0]};
      else if (rise_cnt < 32) addr_sn = {addr_sn[22:0], dq_o[0]};
      rise_cnt++;
      if (rise_cnt == 32) begin
        chk("cmd", {24'd0, cmd_sn}, {24'd0, EXP_CMD});
        if (exp_addr_q.size() > 0) chk("addr", {8'd0, addr_sn}, {8'd0, exp_addr_q.pop_front()});
        else begin
          checks++; errors++;
          $display("FAIL addr: transaction %h with no request issued", addr_sn);
        end
      end
    end
  end

  always @(negedge qspi_sclk) begin
    if (!qspi_cs) begin
      fk = rise_cnt - 32 - D;
      if (fk >= 0 && fk < ND) begin
`ifdef QSPI_QUAD_EN
        fbyte = flash_byte(addr_sn + 24'(fk / 2));
        dq_i  = (fk % 2 == 0) ? fbyte[7:4] : fbyte[3:0];
`else
        fbyte = flash_byte(addr_sn + 24'(fk / 8));
        dq_i  = {2'($urandom), fbyte[7 - (fk % 8)], 1'($urandom)};
`endif
      end else begin
        dq_i = 4'($urandom);
      end
    end
  end

  // ---------------- consumer side ----------------
  initial begin
    forever begin
      @(posedge clock); #1;
      case (rr_mode)
        0: resp_ready = 1;
        1: resp_ready = 1'($urandom_range(0, 1));
        default: resp_ready = 0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          prev_valid = 0, prev_hs = 0, prev_rdy = 1;
  logic [31:0] prev_data = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_valid = 0; prev_hs = 0; prev_rdy = 1; cs_hi = 1000;
      end else begin
        if (resp_valid && !prev_valid && lat_armed) begin
          chk("latency", 32'(cyc - t_req), 32'(EXP_LAT));
          chk("cs_at_resp", {31'd0, qspi_cs}, 32'd1);
          lat_armed = 0;
        end
        if (prev_valid && !prev_hs) begin
          chk("resp_hold_valid", {31'd0, resp_valid}, 32'd1);
          chk("resp_hold_data", resp_data, prev_data);
        end
        prev_hs = resp_valid && resp_ready;
        if (prev_hs) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_data: unexpected response %h", resp_data);
          end else begin
            chk("resp_data", resp_data, exp_q.pop_front());
          end
          last_data = resp_data;
          h_cyc = cyc; gap_armed = 1;
        end
        if (req_ready && !prev_rdy && gap_armed) begin
          chk("gap_len", 32'(cyc - h_cyc), 32'(G + 1));
          gap_armed = 0;
        end
        if (!qspi_cs && cs_hi > 0) chk("cs_gap_min", {31'd0, cs_hi >= G}, 32'd1);
        cs_hi = qspi_cs ? cs_hi + 1 : 0;
        prev_valid = resp_valid; prev_data = resp_data; prev_rdy = req_ready;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_read(input logic [23:0] a);
    int n = 0;
    @(posedge clock); #1;
    req_valid = 1; req_addr = a;
    forever begin
      @(negedge clock);
      if (req_ready) break;
      n++;
      if (n > 5000) begin
        checks++; errors++;
        $display("FAIL req_timeout: req_ready 0 expected 1");
        req_valid = 0;
        return;
      end
    end
    exp_q.push_back(model_word(a));
    exp_addr_q.push_back({a[23:2], 2'b00});
    t_req = cyc; lat_armed = 1;
    @(posedge clock); #1;
    req_valid = 0; req_addr = 24'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clock); n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic junk_pulse();
    @(posedge clock); #1;
    if (!req_ready) begin
      req_valid = 1; req_addr = 24'($urandom);
      @(posedge clock); #1;
      req_valid = 0;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] cap;
    int bad, n;
    #22;
    chk("rst_cs", {31'd0, qspi_cs}, 32'd1);
    chk("rst_sclk", {31'd0, qspi_sclk}, 32'd0);
    chk("rst_oe", {28'd0, dq_oe}, 32'd0);
    chk("rst_dq_o", {28'd0, dq_o}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock); reset = 0;

    // Fixed image at address 0.
    rr_mode = 0;
    do_read(24'h000000);
    wait_idle();
    chk("image_word", last_data, 32'h44332211);

    // Low address bits are ignored on the wire.
    do_read(24'h000106);
    wait_idle();

    // Backpressure on the response.
    rr_mode = 2;
    do_read(24'h000020);
    n = 0;
    while (!resp_valid && n < 2000) begin @(negedge clock); n++; end
    chk("bp_resp_seen", {31'd0, resp_valid}, 32'd1);
    cap = resp_data; bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (!resp_valid || resp_data !== cap || !qspi_cs || req_ready) bad++;
    end
    chk("bp_stable_cycles_bad", 32'(bad), 32'd0);
    chk("bp_data", cap, model_word(24'h000020));
    rr_mode = 0;
    wait_idle();

    // Asynchronous reset in the address phase.
    do_read(24'h000040);
    n = 0;
    while (rise_cnt < 12 && n < 2000) begin @(negedge clock); n++; end
    chk("addr_phase_reached", {31'd0, rise_cnt >= 12}, 32'd1);
    #2 reset = 1;
    #1;
    chk("arst_cs", {31'd0, qspi_cs}, 32'd1);
    chk("arst_sclk", {31'd0, qspi_sclk}, 32'd0);
    chk("arst_oe", {28'd0, dq_oe}, 32'd0);
    chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete(); exp_addr_q.delete();
    lat_armed = 0; gap_armed = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    do_read(24'h000004);
    wait_idle();

    // Back-to-back random reads with random consumer stalls and ignored requests while busy.
    rr_mode = 1;
    do_read(24'hFFFFFC);
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) junk_pulse();
      do_read(24'($urandom));
    end
    wait_idle();
    rr_mode = 0;
    repeat (20) @(negedge clock);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("exp_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
